// File: rtl/vx_wb_arbiter_pkg.sv
// Shared writeback-arbiter definitions: requester indices, default
// geometry, lock FSM states and the round-robin pointer wrap helper.
package vx_wb_arbiter_pkg;

    // Commit-stream requester indices, shared with the instantiating core
    localparam int WB_REQ_ALU  = 0;
    localparam int WB_REQ_LSU  = 1;
    localparam int WB_REQ_CSR  = 2;
    localparam int WB_REQ_FPU  = 3;
    localparam int WB_REQ_GPU  = 4;
    localparam int WB_NUM_REQS = 5;

    // Default datapath geometry
    localparam int WB_NUM_THREADS = 4;
    localparam int WB_NW_BITS     = 2;
    localparam int WB_NR_BITS     = 5;

    // IDLE: free arbitration; LOCKED: a multi-beat packet owns the port
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Advance an index by one, wrapping at n rather than at a power of two
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vx_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: starting at ptr and wrapping modulo
// NUM_REQS, returns the first valid requester as one-hot and as an index.
module vx_wb_arbiter_rr_picker
    import vx_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQS = WB_NUM_REQS,
    parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [IDX_W-1:0]    ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [IDX_W-1:0]    index
);

    int               pos;
    logic [IDX_W-1:0] pos_idx;
    logic             found;

    // Scan from the priority pointer, first valid hit wins
    always_comb begin
        grant   = '0;
        index   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQS) begin
                pos = pos - NUM_REQS;
            end
            pos_idx = IDX_W'(pos);
            if (!found && valid[pos_idx]) begin
                found          = 1'b1;
                grant[pos_idx] = 1'b1;
                index          = pos_idx;
            end
        end
    end

endmodule

// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: shares the single GPR write port among the commit
// streams with round-robin fairness, holds the grant across multi-beat
// packets until eop, and registers the winning beat onto the wb bus.
module vx_wb_arbiter
    import vx_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = WB_NUM_REQS,
    parameter int NUM_THREADS = WB_NUM_THREADS,
    parameter int NW_BITS     = WB_NW_BITS,
    parameter int NR_BITS     = WB_NR_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid,
    input  logic [NUM_REQS*NW_BITS-1:0]        req_wid,
    input  logic [NUM_REQS*32-1:0]             req_PC,
    input  logic [NUM_REQS*NUM_THREADS-1:0]    req_tmask,
    input  logic [NUM_REQS*NR_BITS-1:0]        req_rd,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]                req_eop,
    output logic [NUM_REQS-1:0]                req_ready,
    output logic                               wb_valid,
    output logic [NW_BITS-1:0]                 wb_wid,
    output logic [31:0]                        wb_PC,
    output logic [NUM_THREADS-1:0]             wb_tmask,
    output logic [NR_BITS-1:0]                 wb_rd,
    output logic [NUM_THREADS*32-1:0]          wb_data,
    output logic                               wb_eop
);

    localparam int IDX_W  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int LANE_W = NUM_THREADS * 32;

    arb_state_e          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    lock_idx;
    logic [NUM_REQS-1:0] pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    grant_idx;
    logic                fire;
    logic                grant_eop;

    vx_wb_arbiter_rr_picker #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) rr_picker (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .index (pick_idx)
    );

    // While locked only the packet owner can be granted, otherwise round-robin
    always_comb begin
        req_ready = '0;
        grant_idx = pick_idx;
        if (state == ARB_LOCKED) begin
            grant_idx = lock_idx;
            if (req_valid[lock_idx]) begin
                req_ready = NUM_REQS'(1) << lock_idx;
            end
        end else begin
            req_ready = pick_grant;
        end
        fire      = |(req_valid & req_ready);
        grant_eop = req_eop[grant_idx];
    end

    // Lock FSM: non-eop beats lock the owner, an eop beat frees the port and
    // moves the priority pointer just past the requester that finished
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else if (fire) begin
            if (grant_eop) begin
                state  <= ARB_IDLE;
                rr_ptr <= IDX_W'(wrap_inc(32'(grant_idx), NUM_REQS));
            end else begin
                state    <= ARB_LOCKED;
                lock_idx <= grant_idx;
            end
        end
    end

    // Writeback register: payload only reloads on a fired beat, else holds
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_wid   <= '0;
            wb_PC    <= '0;
            wb_tmask <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_eop   <= 1'b0;
        end else begin
            wb_valid <= fire;
            if (fire) begin
                wb_wid   <= req_wid[grant_idx*NW_BITS +: NW_BITS];
                wb_PC    <= req_PC[grant_idx*32 +: 32];
                wb_tmask <= req_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
                wb_rd    <= req_rd[grant_idx*NR_BITS +: NR_BITS];
                wb_data  <= req_data[grant_idx*LANE_W +: LANE_W];
                wb_eop   <= grant_eop;
            end
        end
    end

    // Grant sanity: one-hot0, only to valid requesters, only to owner when locked
    a_ready_onehot0: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));
    a_ready_valid: assert property (@(posedge clk) disable iff (reset)
        (req_ready & ~req_valid) == '0);
    a_ready_locked: assert property (@(posedge clk) disable iff (reset)
        (state == ARB_LOCKED) |-> ((req_ready & ~(NUM_REQS'(1) << lock_idx)) == '0));

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Self-checking bench for vx_wb_arbiter: directed scenarios plus random
// traffic, all compared against a queue-free behavioural arbitration model.
module tb_vx_wb_arbiter;
    import vx_wb_arbiter_pkg::*;

    localparam int N  = 5;
    localparam int T  = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int PW = NW + 32 + T + NR + 1 + T*32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*NW-1:0]   req_wid = '0;
    logic [N*32-1:0]   req_PC = '0;
    logic [N*T-1:0]    req_tmask = '0;
    logic [N*NR-1:0]   req_rd = '0;
    logic [N*T*32-1:0] req_data = '0;
    logic [N-1:0]      req_eop = '0;
    logic [N-1:0]      req_ready;
    logic              wb_valid;
    logic [NW-1:0]     wb_wid;
    logic [31:0]       wb_PC;
    logic [T-1:0]      wb_tmask;
    logic [NR-1:0]     wb_rd;
    logic [T*32-1:0]   wb_data;
    logic              wb_eop;
    logic [PW-1:0]     wb_payload;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current packet owner (-1 = none), priority start,
    // and the expected content of the writeback register
    int            m_owner;
    int            m_ptr;
    logic          exp_valid;
    logic [PW-1:0] exp_payload;

    vx_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wid   (req_wid),
        .req_PC    (req_PC),
        .req_tmask (req_tmask),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_eop   (req_eop),
        .req_ready (req_ready),
        .wb_valid  (wb_valid),
        .wb_wid    (wb_wid),
        .wb_PC     (wb_PC),
        .wb_tmask  (wb_tmask),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_eop    (wb_eop)
    );

    assign wb_payload = {wb_wid, wb_PC, wb_tmask, wb_rd, wb_eop, wb_data};

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] beat_of(input int i);
        return {req_wid[i*NW +: NW], req_PC[i*32 +: 32], req_tmask[i*T +: T],
                req_rd[i*NR +: NR], req_eop[i], req_data[i*T*32 +: T*32]};
    endfunction

    // Who should win this cycle, from the arbitration rules alone
    function automatic int model_grant();
        if (m_owner >= 0) begin
            return req_valid[m_owner] ? m_owner : -1;
        end
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_commit(input int gi);
        exp_valid = (gi >= 0);
        if (gi >= 0) begin
            exp_payload = beat_of(gi);
            if (req_eop[gi]) begin
                m_owner = -1;
                m_ptr   = (gi + 1) % N;
            end else begin
                m_owner = gi;
            end
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_ptr       = 0;
        exp_valid   = 1'b0;
        exp_payload = '0;
    endtask

    // Drive valid/eop masks with fresh random payload on every requester
    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] e);
        for (int i = 0; i < N; i++) begin
            req_wid[i*NW +: NW]       = NW'($urandom);
            req_PC[i*32 +: 32]        = $urandom;
            req_tmask[i*T +: T]       = T'($urandom);
            req_rd[i*NR +: NR]        = NR'($urandom);
            req_data[i*T*32 +: T*32]  = {$urandom, $urandom, $urandom, $urandom};
        end
        req_valid = v;
        req_eop   = e;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive('1, '1);
        @(posedge clk);
        #1;
        n_checks++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_wb_valid: got %b want 0", wb_valid);
        end
        n_checks++;
        if (wb_payload !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_payload: got %h want 0", wb_payload);
        end
        n_checks++;
        if (req_ready !== 5'b00001) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b want 00001", req_ready);
        end
        do_reset();
    endtask

    task automatic test_alu_burst();
        int g;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive((k <= 3) ? 5'b00001 : 5'b00000, 5'b00001);
            req_rd[NR-1:0] = NR'(k);
            #1;
            g = model_grant();
            @(posedge clk);
            model_commit(g);
            #1;
            n_checks++;
            if (wb_valid !== (k <= 3)) begin
                n_fail++;
                $display("[TB] FAIL alu_burst_valid beat %0d: got %b want %b", k, wb_valid, k <= 3);
            end
            if (k <= 3) begin
                n_checks++;
                if (wb_rd !== NR'(k)) begin
                    n_fail++;
                    $display("[TB] FAIL alu_burst_rd beat %0d: got %0d want %0d", k, wb_rd, k);
                end
            end
            n_checks++;
            if (wb_payload !== exp_payload) begin
                n_fail++;
                $display("[TB] FAIL alu_burst_payload beat %0d: got %h want %h", k, wb_payload, exp_payload);
            end
        end
    endtask

    task automatic test_fairness();
        int g;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            drive(5'b11111, 5'b11111);
            #1;
            g = model_grant();
            n_checks++;
            if (req_ready !== (5'b00001 << (c % N))) begin
                n_fail++;
                $display("[TB] FAIL fairness_ready cycle %0d: got %b want %b", c, req_ready, 5'b00001 << (c % N));
            end
            @(posedge clk);
            model_commit(g);
            #1;
            n_checks++;
            if (wb_valid !== exp_valid || wb_payload !== exp_payload) begin
                n_fail++;
                $display("[TB] FAIL fairness_wb cycle %0d: got %b/%h want %b/%h", c, wb_valid, wb_payload, exp_valid, exp_payload);
            end
        end
    endtask

    // Table-driven scenario: per-cycle valid/eop masks and the required grant
    task automatic run_table(input string name, input logic [N-1:0] v[],
                             input logic [N-1:0] e[], input logic [N-1:0] want[]);
        int g;
        for (int c = 0; c < v.size(); c++) begin
            drive(v[c], e[c]);
            #1;
            g = model_grant();
            n_checks++;
            if (req_ready !== want[c]) begin
                n_fail++;
                $display("[TB] FAIL %s_ready cycle %0d: got %b want %b", name, c, req_ready, want[c]);
            end
            @(posedge clk);
            model_commit(g);
            #1;
            n_checks++;
            if (wb_valid !== exp_valid || wb_payload !== exp_payload) begin
                n_fail++;
                $display("[TB] FAIL %s_wb cycle %0d: got %b/%h want %b/%h", name, c, wb_valid, wb_payload, exp_valid, exp_payload);
            end
        end
    endtask

    task automatic test_lsu_lock();
        logic [N-1:0] v[]    = '{5'b00010, 5'b01011, 5'b01011, 5'b01011, 5'b01011};
        logic [N-1:0] e[]    = '{5'b00000, 5'b01001, 5'b01011, 5'b01011, 5'b01011};
        logic [N-1:0] want[] = '{5'b00010, 5'b00010, 5'b00010, 5'b01000, 5'b00001};
        do_reset();
        run_table("lsu_lock", v, e, want);
    endtask

    task automatic test_lock_bubbles();
        logic [N-1:0] v[]    = '{5'b00010, 5'b10000, 5'b10000, 5'b10010, 5'b10000};
        logic [N-1:0] e[]    = '{5'b10000, 5'b10000, 5'b10000, 5'b10010, 5'b10000};
        logic [N-1:0] want[] = '{5'b00010, 5'b00000, 5'b00000, 5'b00010, 5'b10000};
        do_reset();
        run_table("lock_bubbles", v, e, want);
    endtask

    task automatic test_gpu_wrap();
        logic [N-1:0] v[]    = '{5'b10000, 5'b00101, 5'b00101};
        logic [N-1:0] e[]    = '{5'b10000, 5'b00101, 5'b00101};
        logic [N-1:0] want[] = '{5'b10000, 5'b00001, 5'b00100};
        do_reset();
        run_table("gpu_wrap", v, e, want);
    endtask

    task automatic test_reset_midpacket();
        int g;
        do_reset();
        drive(5'b01000, 5'b00000);
        #1;
        g = model_grant();
        @(posedge clk);
        model_commit(g);
        #1;
        drive(5'b01000, 5'b00000);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (wb_valid !== 1'b0 || wb_payload !== '0) begin
            n_fail++;
            $display("[TB] FAIL midpacket_reset_wb: got %b/%h want 0/0", wb_valid, wb_payload);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(5'b01100, 5'b01100);
        #1;
        g = model_grant();
        n_checks++;
        if (req_ready !== 5'b00100) begin
            n_fail++;
            $display("[TB] FAIL midpacket_restart_ready: got %b want 00100", req_ready);
        end
        @(posedge clk);
        model_commit(g);
        #1;
        n_checks++;
        if (wb_valid !== 1'b1 || wb_payload !== exp_payload) begin
            n_fail++;
            $display("[TB] FAIL midpacket_restart_wb: got %b/%h want 1/%h", wb_valid, wb_payload, exp_payload);
        end
    endtask

    task automatic test_random();
        int           g;
        logic [N-1:0] want;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(N'($urandom), N'($urandom | $urandom));
            #1;
            g    = model_grant();
            want = '0;
            if (g >= 0) want[g] = 1'b1;
            n_checks++;
            if (req_ready !== want) begin
                n_fail++;
                $display("[TB] FAIL random_ready cycle %0d: got %b want %b", c, req_ready, want);
            end
            @(posedge clk);
            model_commit(g);
            #1;
            n_checks++;
            if (wb_valid !== exp_valid || wb_payload !== exp_payload) begin
                n_fail++;
                $display("[TB] FAIL random_wb cycle %0d: got %b/%h want %b/%h", c, wb_valid, wb_payload, exp_valid, exp_payload);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alu_burst();
        test_fairness();
        test_lsu_lock();
        test_lock_bubbles();
        test_gpu_wrap();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
